wb_host_master: RTL and testbench
=================================

// Module: wb_host_master
// PURPOSE
//  Single-outstanding Wishbone pipelined master feeding the generated register slaves.
//  Converts a valid/ready command stream into one WB cycle per command.
//  Returns read data plus a completion status on a valid/ready response stream.
//  Bounds every cycle with a timeout and retries on rty.
// PARAMETERS
//  ADDR_W    32   width of cmd_adr_i / wb_adr_o (byte address, passed through unchanged)
//  TIMEOUT   255  max cycles from stb assertion to termination; 1..65535
//  RETRY_MAX 3    extra attempts after rty before giving up; 0..15
// PORTS
//  clk_i         in   1       clock, all logic on rising edge
//  rst_i         in   1       synchronous reset, active-high
//  cmd_valid_i   in   1       command present
//  cmd_ready_o   out  1       command accepted when valid&ready
//  cmd_we_i      in   1       1=write, 0=read
//  cmd_adr_i     in   ADDR_W  target address
//  cmd_sel_i     in   4       byte selects
//  cmd_dat_i     in   32      write data
//  rsp_valid_o   out  1       response present
//  rsp_ready_i   in   1       response consumed when valid&ready
//  rsp_dat_o     out  32      read data (0 for writes and failed cycles)
//  rsp_sts_o     out  2       00 OK, 01 ERR, 10 RTY exhausted, 11 TIMEOUT
//  wb_cyc_o      out  1       WB cycle
//  wb_stb_o      out  1       WB strobe
//  wb_we_o       out  1       WB write enable
//  wb_adr_o      out  ADDR_W  WB address
//  wb_sel_o      out  4       WB byte selects
//  wb_dat_o      out  32      WB write data
//  wb_ack_i      in   1       WB ack
//  wb_err_i      in   1       WB error
//  wb_rty_i      in   1       WB retry
//  wb_stall_i    in   1       WB stall
//  wb_dat_i      in   32      WB read data
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready_o=1, rsp_valid_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, all data/adr/sel/sts regs 0.
//  cmd_ready_o = (state==IDLE). Command fields registered on accept; held stable on wb_* until next accept.
//  FSM:
//   IDLE : cmd accept -> REQ next cycle; retry_cnt=0, tmo_cnt=0.
//   REQ  : cyc=1, stb=1. ack/err/rty seen (any stall value) -> terminate. Else stall=0 -> WAIT.
//   WAIT : cyc=1, stb=0. ack/err/rty -> terminate.
//   BACKOFF: cyc=0, stb=0 for exactly 1 cycle, tmo_cnt cleared -> REQ.
//   RESP : cyc=0, rsp_valid_o=1 and fields stable until rsp_ready_i; then IDLE.
//  Terminate priority when several asserted in one cycle: err > rty > ack.
//   ack: sts=00, rsp_dat = wb_dat_i if read else 0 -> RESP.
//   err: sts=01, rsp_dat=0 -> RESP.
//   rty: retry_cnt<RETRY_MAX -> retry_cnt++, BACKOFF; else sts=10, rsp_dat=0 -> RESP.
//  Timeout: tmo_cnt increments each cycle in REQ/WAIT; if no termination after TIMEOUT cycles
//   (cycle index TIMEOUT-1 ends without ack/err/rty) -> sts=11, rsp_dat=0, cyc/stb drop next cycle -> RESP.
//   Termination in the same cycle the count expires wins over timeout.
//  Latency: accept at cycle 0 -> stb at cycle 1; zero-wait slave acking at cycle k -> rsp_valid_o at k+1.
//  wb_cyc_o deasserts on the cycle after termination; never more than one outstanding stb.
//  rst_i mid-cycle: cyc/stb drop next edge, pending response discarded, no response emitted.
//  Back-to-back: new command accepted only in IDLE, so min 1 idle cycle between WB cycles.
// TESTING
//  1 Write adr=0x8 dat=0xDEADBEEF sel=F, slave stalls 2 then acks -> one stb, rsp sts=00 dat=0.
//  2 Read adr=0x0, slave acks with 0x00000015 -> rsp_dat_o=0x00000015, sts=00, rsp 1 cycle after ack.
//  3 Slave answers rty 4 times (RETRY_MAX=3) -> 4 REQ phases each with 1-cycle cyc gap, sts=10.
//  4 Slave never acks, TIMEOUT=8 -> cyc high 8 cycles then drops, sts=11, rsp_dat=0.
//  5 ack and err same cycle -> sts=01; rsp_ready_i low 5 cycles -> rsp held, cmd_ready_o=0 throughout.
//  6 rst_i pulsed while in WAIT -> cyc=0 next cycle, no rsp_valid_o, cmd_ready_o=1 after reset.

Source files
------------

// File: rtl/wb_host_master.sv
// wb_host_master: single-outstanding Wishbone pipelined master.
// One WB cycle per accepted command, bounded by a timeout, retried on rty,
// with the outcome returned on a valid/ready response stream.
module wb_host_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned RETRY_MAX = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [3:0]        cmd_sel_i,
  input  logic [31:0]       cmd_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_dat_o,
  output logic [1:0]        rsp_sts_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic              wb_stall_i,
  input  logic [31:0]       wb_dat_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_BACKOFF,
    S_RESP
  } state_t;

  localparam logic [1:0]  STS_OK  = 2'b00;
  localparam logic [1:0]  STS_ERR = 2'b01;
  localparam logic [1:0]  STS_RTY = 2'b10;
  localparam logic [1:0]  STS_TMO = 2'b11;
  // Last cycle index at which a termination may still arrive.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RTY_LIMIT = 4'(RETRY_MAX);

  state_t      state, state_nx;
  logic [15:0] tmo_cnt, tmo_nx;
  logic [3:0]  retry_cnt, retry_nx;
  logic        cmd_ld, rsp_ld;
  logic [1:0]  sts_nx;
  logic [31:0] dat_nx;

  // Handshake and bus strobes decode directly from the state.
  assign cmd_ready_o = (state == S_IDLE);
  assign rsp_valid_o = (state == S_RESP);
  assign wb_cyc_o    = (state == S_REQ) || (state == S_WAIT);
  assign wb_stb_o    = (state == S_REQ);

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state, counter and capture-enable decode.
  always_comb begin
    state_nx = state;
    tmo_nx   = tmo_cnt;
    retry_nx = retry_cnt;
    cmd_ld   = 1'b0;
    rsp_ld   = 1'b0;
    sts_nx   = STS_OK;
    dat_nx   = '0;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          cmd_ld   = 1'b1;
          tmo_nx   = '0;
          retry_nx = '0;
          state_nx = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        tmo_nx = tmo_cnt + 16'd1;
        if (wb_err_i) begin
          rsp_ld   = 1'b1;
          sts_nx   = STS_ERR;
          state_nx = S_RESP;
        end else if (wb_rty_i) begin
          if (retry_cnt < RTY_LIMIT) begin
            retry_nx = retry_cnt + 4'd1;
            state_nx = S_BACKOFF;
          end else begin
            rsp_ld   = 1'b1;
            sts_nx   = STS_RTY;
            state_nx = S_RESP;
          end
        end else if (wb_ack_i) begin
          rsp_ld   = 1'b1;
          sts_nx   = STS_OK;
          dat_nx   = wb_we_o ? '0 : wb_dat_i;
          state_nx = S_RESP;
        end else if (tmo_cnt == TMO_LAST) begin
          rsp_ld   = 1'b1;
          sts_nx   = STS_TMO;
          state_nx = S_RESP;
        end else if ((state == S_REQ) && !wb_stall_i) begin
          state_nx = S_WAIT;
        end
      end
      S_BACKOFF: begin
        tmo_nx   = '0;
        state_nx = S_REQ;
      end
      S_RESP: begin
        if (rsp_ready_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters, captured command fields and response fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt   <= '0;
      retry_cnt <= '0;
      wb_we_o   <= 1'b0;
      wb_adr_o  <= '0;
      wb_sel_o  <= '0;
      wb_dat_o  <= '0;
      rsp_sts_o <= '0;
      rsp_dat_o <= '0;
    end else begin
      tmo_cnt   <= tmo_nx;
      retry_cnt <= retry_nx;
      if (cmd_ld) begin
        wb_we_o  <= cmd_we_i;
        wb_adr_o <= cmd_adr_i;
        wb_sel_o <= cmd_sel_i;
        wb_dat_o <= cmd_dat_i;
      end
      if (rsp_ld) begin
        rsp_sts_o <= sts_nx;
        rsp_dat_o <= dat_nx;
      end
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// tb_wb_host_master: directed vector table plus randomized transactions
// against an attempt-level reference model of wb_host_master.
module tb_wb_host_master;

  localparam int TMO  = 8;
  localparam int RMAX = 3;

  // Slave reaction for one attempt.
  localparam logic [2:0] K_ACK    = 3'd0;
  localparam logic [2:0] K_ERR    = 3'd1;
  localparam logic [2:0] K_RTY    = 3'd2;
  localparam logic [2:0] K_NONE   = 3'd3;
  localparam logic [2:0] K_ACKERR = 3'd4;
  localparam logic [2:0] K_RTYACK = 3'd5;
  localparam logic [2:0] K_ERRRTY = 3'd6;

  logic        clk = 1'b0;
  logic        rst_i, cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i, rsp_dat_o, wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0]  cmd_sel_i, wb_sel_o;
  logic        rsp_valid_o, rsp_ready_i;
  logic [1:0]  rsp_sts_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i;

  always #5 clk = ~clk;

  wb_host_master #(.ADDR_W(32), .TIMEOUT(TMO), .RETRY_MAX(RMAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_sel_i(cmd_sel_i), .cmd_dat_i(cmd_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_sts_o(rsp_sts_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
    .wb_stall_i(wb_stall_i), .wb_dat_i(wb_dat_i)
  );

  // Attempt fields are packed with attempt 0 in the rightmost slot.
  typedef struct packed {
    logic            we;
    logic [31:0]     adr;
    logic [3:0]      sel;
    logic [31:0]     dat;
    int              n_att;
    logic [4:0][2:0] kind;
    logic [4:0][7:0] d;
    logic [4:0][7:0] st;
    logic [31:0]     rdata;
    int              hold;
    logic [1:0]      exp_sts;
    logic [31:0]     exp_dat;
    int              exp_lat;
  } vec_t;

  vec_t vecs [9];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Outcome of a command from the slave's per-attempt reactions:
  // status, data, cycles from accept to rsp_valid, and number of stb phases.
  function automatic void model(input logic we, input logic [31:0] rdata,
                                input logic [4:0][2:0] kind, input logic [4:0][7:0] d,
                                input int n_att, output logic [1:0] sts,
                                output logic [31:0] dat, output int lat, output int phases);
    int retries;
    retries = 0;
    lat     = 1;
    phases  = 0;
    sts     = 2'b11;
    dat     = '0;
    for (int a = 0; a < n_att; a++) begin
      phases++;
      if (kind[a] == K_NONE || int'(d[a]) >= TMO) begin
        sts = 2'b11;
        lat += TMO;
        return;
      end
      lat += int'(d[a]) + 1;
      if (kind[a] == K_ERR || kind[a] == K_ACKERR || kind[a] == K_ERRRTY) begin
        sts = 2'b01;
        return;
      end
      if (kind[a] == K_RTY || kind[a] == K_RTYACK) begin
        if (retries < RMAX) begin
          retries++;
          lat += 1;
          continue;
        end
        sts = 2'b10;
        return;
      end
      sts = 2'b00;
      dat = we ? 32'h0 : rdata;
      return;
    end
    phases++;
    lat += TMO;
    sts = 2'b11;
  endfunction

  task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat,
                         input logic [4:0][2:0] kind, input logic [4:0][7:0] d,
                         input logic [4:0][7:0] st, input int n_att,
                         input logic [31:0] rdata, input int hold,
                         input logic [1:0] exp_sts, input logic [31:0] exp_dat,
                         input int exp_lat, input int exp_phases);
    int cyc_n, c, a, phases, gaps, guard, accepted;
    bit in_att, got, stb_bad, fld_bad, busy_bad, hold_bad;
    logic [2:0]  k;
    logic [1:0]  s_sts;
    logic [31:0] s_dat;
    cyc_n = 0; c = 0; a = 0; phases = 0; gaps = 0; guard = 0; accepted = 0;
    in_att = 0; got = 0; stb_bad = 0; fld_bad = 0; busy_bad = 0; hold_bad = 0;
    cmd_we_i = we; cmd_adr_i = adr; cmd_sel_i = sel; cmd_dat_i = dat;
    cmd_valid_i = 1'b1;
    while (!cmd_ready_o && guard < 50) begin
      step();
      guard++;
    end
    check({tag, " cmd_ready"}, {31'b0, cmd_ready_o}, 32'd1);
    step();
    cmd_valid_i = 1'b0;
    cmd_we_i = 1'($urandom); cmd_adr_i = $urandom; cmd_sel_i = 4'($urandom); cmd_dat_i = $urandom;
    cyc_n = 1;
    while (!got && cyc_n < 300) begin
      if (rsp_valid_o) begin
        got = 1;
      end else begin
        wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0;
        wb_dat_i = $urandom;
        if (cmd_ready_o) busy_bad = 1;
        if (wb_cyc_o) begin
          if (!in_att) begin
            in_att = 1; c = 0; accepted = 0; phases++;
            if (!wb_stb_o) stb_bad = 1;
          end
          if (wb_we_o !== we || wb_adr_o !== adr || wb_sel_o !== sel || wb_dat_o !== dat)
            fld_bad = 1;
          k = (a < n_att && a < 5) ? kind[a] : K_NONE;
          wb_stall_i = (a < 5) && (c < int'(st[a]));
          if (k != K_NONE && c == int'(d[a])) begin
            wb_ack_i = (k == K_ACK || k == K_ACKERR || k == K_RTYACK);
            wb_err_i = (k == K_ERR || k == K_ACKERR || k == K_ERRRTY);
            wb_rty_i = (k == K_RTY || k == K_RTYACK || k == K_ERRRTY);
            wb_dat_i = rdata;
          end
          if (wb_stb_o && !wb_stall_i) accepted++;
          if (accepted > 1) stb_bad = 1;
          c++;
        end else begin
          if (in_att) begin
            in_att = 0;
            a++;
          end
          gaps++;
        end
        step();
        cyc_n++;
      end
    end
    wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0;
    check({tag, " rsp_seen"}, {31'b0, got}, 32'd1);
    check({tag, " latency"}, cyc_n, exp_lat);
    check({tag, " sts"}, {30'b0, rsp_sts_o}, {30'b0, exp_sts});
    check({tag, " dat"}, rsp_dat_o, exp_dat);
    check({tag, " stb_phases"}, phases, exp_phases);
    check({tag, " backoff_gaps"}, gaps, exp_phases - 1);
    check({tag, " stb_single"}, {31'b0, stb_bad}, 32'd0);
    check({tag, " wb_fields"}, {31'b0, fld_bad}, 32'd0);
    check({tag, " ready_busy"}, {31'b0, busy_bad}, 32'd0);
    s_sts = rsp_sts_o;
    s_dat = rsp_dat_o;
    if (cmd_ready_o || wb_cyc_o) hold_bad = 1;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!rsp_valid_o || rsp_sts_o !== s_sts || rsp_dat_o !== s_dat || cmd_ready_o || wb_cyc_o)
        hold_bad = 1;
    end
    check({tag, " rsp_hold"}, {31'b0, hold_bad}, 32'd0);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check({tag, " rsp_done"}, {30'b0, rsp_valid_o, cmd_ready_o}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [4:0][2:0] kind;
    logic [4:0][7:0] d, st;
    logic [1:0]  m_sts;
    logic [31:0] m_dat, adr, dat, rdata;
    logic [3:0]  sel;
    logic        we;
    int          m_lat, m_ph, n, r, guard;
    bit          bad;

    rst_i = 1; cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = '0; cmd_sel_i = '0; cmd_dat_i = '0;
    rsp_ready_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_rty_i = 0; wb_stall_i = 0; wb_dat_i = '0;

    // {inputs, slave script, expected} for the directed cases
    vecs[0] = '{we:1'b1, adr:32'h8, sel:4'hF, dat:32'hDEADBEEF, n_att:1,
                kind:{K_NONE, K_NONE, K_NONE, K_NONE, K_ACK}, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd3},
                st:{8'd0, 8'd0, 8'd0, 8'd0, 8'd2}, rdata:32'h12345678, hold:0,
                exp_sts:2'b00, exp_dat:32'h0, exp_lat:5};
    vecs[1] = '{we:1'b0, adr:32'h0, sel:4'hF, dat:32'h0, n_att:1,
                kind:{K_NONE, K_NONE, K_NONE, K_NONE, K_ACK}, d:'0, st:'0,
                rdata:32'h00000015, hold:1, exp_sts:2'b00, exp_dat:32'h15, exp_lat:2};
    vecs[2] = '{we:1'b0, adr:32'h10, sel:4'h3, dat:32'h0, n_att:4,
                kind:{K_NONE, K_RTY, K_RTY, K_RTY, K_RTY}, d:{8'd0, 8'd1, 8'd1, 8'd1, 8'd1},
                st:'0, rdata:32'hCAFE0001, hold:0, exp_sts:2'b10, exp_dat:32'h0, exp_lat:12};
    vecs[3] = '{we:1'b0, adr:32'h20, sel:4'hF, dat:32'h0, n_att:1,
                kind:{K_NONE, K_NONE, K_NONE, K_NONE, K_NONE}, d:'0, st:'0,
                rdata:32'hFFFFFFFF, hold:0, exp_sts:2'b11, exp_dat:32'h0, exp_lat:9};
    vecs[4] = '{we:1'b0, adr:32'h24, sel:4'hF, dat:32'h0, n_att:1,
                kind:{K_NONE, K_NONE, K_NONE, K_NONE, K_ACKERR}, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd1},
                st:'0, rdata:32'h77777777, hold:5, exp_sts:2'b01, exp_dat:32'h0, exp_lat:3};
    vecs[5] = '{we:1'b0, adr:32'h28, sel:4'hF, dat:32'h0, n_att:2,
                kind:{K_NONE, K_NONE, K_NONE, K_ACK, K_RTY}, d:'0, st:'0,
                rdata:32'hA5A51234, hold:2, exp_sts:2'b00, exp_dat:32'hA5A51234, exp_lat:4};
    vecs[6] = '{we:1'b1, adr:32'h2C, sel:4'h1, dat:32'h55AA55AA, n_att:1,
                kind:{K_NONE, K_NONE, K_NONE, K_NONE, K_ERRRTY}, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd2},
                st:'0, rdata:32'h11111111, hold:0, exp_sts:2'b01, exp_dat:32'h0, exp_lat:4};
    vecs[7] = '{we:1'b0, adr:32'h30, sel:4'hF, dat:32'h0, n_att:1,
                kind:{K_NONE, K_NONE, K_NONE, K_NONE, K_ACK}, d:{8'd0, 8'd0, 8'd0, 8'd0, 8'd7},
                st:{8'd0, 8'd0, 8'd0, 8'd0, 8'd1}, rdata:32'h0BADF00D, hold:0,
                exp_sts:2'b00, exp_dat:32'h0BADF00D, exp_lat:9};
    vecs[8] = '{we:1'b0, adr:32'h34, sel:4'hC, dat:32'h0, n_att:4,
                kind:{K_NONE, K_ACK, K_RTY, K_RTY, K_RTY}, d:'0, st:'0,
                rdata:32'h600DD00D, hold:0, exp_sts:2'b00, exp_dat:32'h600DD00D, exp_lat:8};

    repeat (3) step();
    check("reset ready/valid", {30'b0, cmd_ready_o, rsp_valid_o}, 32'd2);
    check("reset cyc/stb/we", {29'b0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
    check("reset adr", wb_adr_o, 32'd0);
    check("reset sel/sts", {26'b0, wb_sel_o, rsp_sts_o}, 32'd0);
    check("reset wdat", wb_dat_o, 32'd0);
    check("reset rdat", rsp_dat_o, 32'd0);
    rst_i = 0;
    step();

    for (int i = 0; i < 9; i++) begin
      model(vecs[i].we, vecs[i].rdata, vecs[i].kind, vecs[i].d, vecs[i].n_att,
            m_sts, m_dat, m_lat, m_ph);
      run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
              vecs[i].kind, vecs[i].d, vecs[i].st, vecs[i].n_att, vecs[i].rdata,
              vecs[i].hold, vecs[i].exp_sts, vecs[i].exp_dat, vecs[i].exp_lat, m_ph);
    end

    // Reset while the cycle waits for its slave.
    cmd_we_i = 0; cmd_adr_i = 32'h40; cmd_sel_i = 4'hF; cmd_dat_i = '0; cmd_valid_i = 1;
    guard = 0;
    while (!cmd_ready_o && guard < 20) begin
      step();
      guard++;
    end
    step();
    cmd_valid_i = 0;
    guard = 0;
    while (!(wb_cyc_o && !wb_stb_o) && guard < 10) begin
      step();
      guard++;
    end
    check("rst in_wait", {30'b0, wb_cyc_o, wb_stb_o}, 32'd2);
    step();
    rst_i = 1;
    step();
    check("rst cyc/stb", {30'b0, wb_cyc_o, wb_stb_o}, 32'd0);
    check("rst ready/valid", {30'b0, cmd_ready_o, rsp_valid_o}, 32'd2);
    rst_i = 0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (rsp_valid_o || wb_cyc_o || !cmd_ready_o) bad = 1;
    end
    check("rst no_rsp", {31'b0, bad}, 32'd0);

    for (int t = 0; t < 40; t++) begin
      we = 1'($urandom_range(0, 1));
      adr = $urandom; sel = 4'($urandom_range(0, 15)); dat = $urandom; rdata = $urandom;
      n = $urandom_range(1, 5);
      for (int i = 0; i < 5; i++) begin
        r = $urandom_range(0, 9);
        kind[i] = (r > 6) ? K_RTY : 3'(r);
        d[i]    = 8'($urandom_range(0, 9));
        st[i]   = 8'($urandom_range(0, 3));
      end
      model(we, rdata, kind, d, n, m_sts, m_dat, m_lat, m_ph);
      run_txn($sformatf("rnd%0d", t), we, adr, sel, dat, kind, d, st, n, rdata,
              $urandom_range(0, 3), m_sts, m_dat, m_lat, m_ph);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
